// File: rtl/decode_stage.sv
// Registered instruction decoder with a 2-entry skid buffer between fetch and EX.
// Optional RVC expansion is enabled by defining RV_COMPRESSED_EN.
module decode_stage #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned ILEN  = 32,
  parameter int unsigned OPT_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ILEN-1:0]   in_instr,
  input  logic [XLEN-1:0]   in_pc,
  input  logic [XLEN-1:0]   in_rs1_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [6:0]        out_opcode,
  output logic [OPT_W-1:0]  out_optype,
  output logic [4:0]        out_rd,
  output logic [4:0]        out_rs1,
  output logic [4:0]        out_rs2,
  output logic [2:0]        out_funct3,
  output logic [6:0]        out_funct7,
  output logic [XLEN-1:0]   out_imm,
  output logic [XLEN-1:0]   out_pc,
  output logic [XLEN-1:0]   out_pc_next,
  output logic [XLEN-1:0]   out_jalr_target,
  output logic              out_compressed,
  output logic              out_illegal
);

  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_LOAD_FP  = 7'b0000111;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_STORE_FP = 7'b0100111;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_MADD     = 7'b1000011;
  localparam logic [6:0] OPC_MSUB     = 7'b1000111;
  localparam logic [6:0] OPC_NMSUB    = 7'b1001011;
  localparam logic [6:0] OPC_NMADD    = 7'b1001111;
  localparam logic [6:0] OPC_OP_FP    = 7'b1010011;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  localparam logic [OPT_W-1:0] T_R   = OPT_W'(0);
  localparam logic [OPT_W-1:0] T_I   = OPT_W'(1);
  localparam logic [OPT_W-1:0] T_S   = OPT_W'(2);
  localparam logic [OPT_W-1:0] T_B   = OPT_W'(3);
  localparam logic [OPT_W-1:0] T_U   = OPT_W'(4);
  localparam logic [OPT_W-1:0] T_J   = OPT_W'(5);
  localparam logic [OPT_W-1:0] T_SYS = OPT_W'(6);

  typedef struct packed {
    logic [6:0]       opcode;
    logic [OPT_W-1:0] optype;
    logic [4:0]       rd;
    logic [4:0]       rs1;
    logic [4:0]       rs2;
    logic [2:0]       funct3;
    logic [6:0]       funct7;
    logic [XLEN-1:0]  imm;
    logic [XLEN-1:0]  pc;
    logic [XLEN-1:0]  pc_next;
    logic [XLEN-1:0]  jalr_target;
    logic             compressed;
    logic             illegal;
  } entry_t;

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

  logic [31:0] instr_x;
  logic        is_c;
  logic        exp_ill;

`ifdef RV_COMPRESSED_EN
  // RV32C to RV32I expansion; unsupported or reserved encodings flag ill
  function automatic void c_expand(input logic [15:0] c, output logic [31:0] x,
                                   output logic ill);
    logic [4:0]  rd;
    logic [4:0]  rs2;
    logic [4:0]  rdp;
    logic [4:0]  rs2p;
    logic [11:1] jimm;
    logic [8:1]  boff;
    logic [9:0]  nzu;
    logic [6:0]  woff;
    logic [7:0]  lsp;
    logic [7:0]  ssp;
    logic [9:0]  sp16;
    rd   = c[11:7];
    rs2  = c[6:2];
    rdp  = {2'b01, c[9:7]};
    rs2p = {2'b01, c[4:2]};
    jimm = {c[12], c[8], c[10:9], c[6], c[7], c[2], c[11], c[5:3]};
    boff = {c[12], c[6:5], c[2], c[11:10], c[4:3]};
    nzu  = {c[10:7], c[12:11], c[5], c[6], 2'b00};
    woff = {c[5], c[12:10], c[6], 2'b00};
    lsp  = {c[3:2], c[12], c[6:4], 2'b00};
    ssp  = {c[8:7], c[12:9], 2'b00};
    sp16 = {c[12], c[4:3], c[5], c[2], c[6], 4'b0000};
    x    = 32'h0;
    ill  = 1'b0;
    case ({c[1:0], c[15:13]})
      5'b00_000: begin
        x   = {2'b00, nzu, 5'd2, 3'b000, rs2p, OPC_OP_IMM};
        ill = (nzu == 10'd0);
      end
      5'b00_010: x = {5'b00000, woff, rdp, 3'b010, rs2p, OPC_LOAD};
      5'b00_110: x = {5'b00000, woff[6:5], rs2p, rdp, 3'b010, woff[4:0], OPC_STORE};
      5'b01_000: x = {{6{c[12]}}, c[12], c[6:2], rd, 3'b000, rd, OPC_OP_IMM};
      5'b01_001: x = {c[12], jimm[10:1], jimm[11], {8{c[12]}}, 5'd1, OPC_JAL};
      5'b01_010: x = {{6{c[12]}}, c[12], c[6:2], 5'd0, 3'b000, rd, OPC_OP_IMM};
      5'b01_011: begin
        if (rd == 5'd2) begin
          x   = {{2{c[12]}}, sp16, 5'd2, 3'b000, 5'd2, OPC_OP_IMM};
          ill = (sp16 == 10'd0);
        end else begin
          x   = {{14{c[12]}}, c[12], c[6:2], rd, OPC_LUI};
          ill = ({c[12], c[6:2]} == 6'd0);
        end
      end
      5'b01_100: begin
        case (c[11:10])
          2'b00: begin
            x   = {7'b0000000, c[6:2], rdp, 3'b101, rdp, OPC_OP_IMM};
            ill = c[12];
          end
          2'b01: begin
            x   = {7'b0100000, c[6:2], rdp, 3'b101, rdp, OPC_OP_IMM};
            ill = c[12];
          end
          2'b10: x = {{6{c[12]}}, c[12], c[6:2], rdp, 3'b111, rdp, OPC_OP_IMM};
          default: begin
            case (c[6:5])
              2'b00:   x = {7'b0100000, rs2p, rdp, 3'b000, rdp, OPC_OP};
              2'b01:   x = {7'b0000000, rs2p, rdp, 3'b100, rdp, OPC_OP};
              2'b10:   x = {7'b0000000, rs2p, rdp, 3'b110, rdp, OPC_OP};
              default: x = {7'b0000000, rs2p, rdp, 3'b111, rdp, OPC_OP};
            endcase
            ill = c[12];
          end
        endcase
      end
      5'b01_101: x = {c[12], jimm[10:1], jimm[11], {8{c[12]}}, 5'd0, OPC_JAL};
      5'b01_110: x = {{3{c[12]}}, boff[8:5], 5'd0, rdp, 3'b000, boff[4:1], c[12], OPC_BRANCH};
      5'b01_111: x = {{3{c[12]}}, boff[8:5], 5'd0, rdp, 3'b001, boff[4:1], c[12], OPC_BRANCH};
      5'b10_000: begin
        x   = {7'b0000000, c[6:2], rd, 3'b001, rd, OPC_OP_IMM};
        ill = c[12];
      end
      5'b10_010: begin
        x   = {4'b0000, lsp, 5'd2, 3'b010, rd, OPC_LOAD};
        ill = (rd == 5'd0);
      end
      5'b10_100: begin
        if (!c[12]) begin
          if (rs2 == 5'd0) begin
            x   = {12'h000, rd, 3'b000, 5'd0, OPC_JALR};
            ill = (rd == 5'd0);
          end else begin
            x   = {7'b0000000, rs2, 5'd0, 3'b000, rd, OPC_OP};
          end
        end else if (rs2 == 5'd0) begin
          x = (rd == 5'd0) ? 32'h00100073 : {12'h000, rd, 3'b000, 5'd1, OPC_JALR};
        end else begin
          x = {7'b0000000, rs2, rd, 3'b000, rd, OPC_OP};
        end
      end
      5'b10_110: x = {4'b0000, ssp[7:5], rs2, 5'd2, 3'b010, ssp[4:0], OPC_STORE};
      default:   ill = 1'b1;
    endcase
  endfunction

  logic [31:0] c_word;
  logic        c_ill;

  // Select the expanded word for 16-bit encodings
  always_comb begin
    c_word = 32'h0;
    c_ill  = 1'b0;
    c_expand(in_instr[15:0], c_word, c_ill);
    is_c    = (in_instr[1:0] != 2'b11);
    instr_x = is_c ? c_word : in_instr[31:0];
    exp_ill = is_c & c_ill;
  end
`else
  // Without the expander any 16-bit encoding is decoded raw and trapped
  always_comb begin
    is_c    = 1'b0;
    instr_x = in_instr[31:0];
    exp_ill = (in_instr[1:0] != 2'b11);
  end
`endif

  entry_t      dec;
  logic        legal;
  logic [31:0] imm32;

  // Field, format and immediate decode of the incoming instruction
  always_comb begin
    dec        = '0;
    legal      = 1'b1;
    imm32      = 32'h0;
    dec.opcode = instr_x[6:0];
    dec.rd     = instr_x[11:7];
    dec.rs1    = instr_x[19:15];
    dec.rs2    = instr_x[24:20];
    dec.funct3 = instr_x[14:12];
    dec.funct7 = instr_x[31:25];
    case (instr_x[6:0])
      OPC_OP, OPC_OP_FP, OPC_MADD, OPC_MSUB, OPC_NMSUB, OPC_NMADD: dec.optype = T_R;
      OPC_OP_IMM, OPC_JALR, OPC_LOAD, OPC_LOAD_FP:                 dec.optype = T_I;
      OPC_STORE, OPC_STORE_FP:                                     dec.optype = T_S;
      OPC_BRANCH:                                                  dec.optype = T_B;
      OPC_LUI, OPC_AUIPC:                                          dec.optype = T_U;
      OPC_JAL:                                                     dec.optype = T_J;
      OPC_SYSTEM:                                                  dec.optype = T_SYS;
      default: begin
        dec.optype = T_R;
        legal      = 1'b0;
      end
    endcase
    case (dec.optype)
      T_I:     imm32 = {{20{instr_x[31]}}, instr_x[31:20]};
      T_S:     imm32 = {{20{instr_x[31]}}, instr_x[31:25], instr_x[11:7]};
      T_B:     imm32 = {{19{instr_x[31]}}, instr_x[31], instr_x[7], instr_x[30:25],
                        instr_x[11:8], 1'b0};
      T_U:     imm32 = {instr_x[31:12], 12'h000};
      T_J:     imm32 = {{11{instr_x[31]}}, instr_x[31], instr_x[19:12], instr_x[20],
                        instr_x[30:21], 1'b0};
      default: imm32 = 32'h0;
    endcase
    dec.imm         = XLEN'($signed(imm32));
    dec.pc          = in_pc;
    dec.pc_next     = in_pc + (is_c ? XLEN'(2) : XLEN'(4));
    dec.jalr_target = (instr_x[6:0] == OPC_JALR) ?
                      ((in_rs1_data + dec.imm) & ~XLEN'(1)) : '0;
    dec.compressed  = is_c;
    dec.illegal     = ~legal | exp_ill;
  end

  state_t state_q, state_d;
  entry_t head_q, head_d;
  entry_t tail_q, tail_d;
  logic   push, pop;

  assign push = in_valid & in_ready;
  assign pop  = out_valid & out_ready;

  // Buffer occupancy and entry movement; head is always the oldest entry
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    case (state_q)
      EMPTY: begin
        if (push) begin
          state_d = ONE;
          head_d  = dec;
        end
      end
      ONE: begin
        if (push && pop) begin
          head_d = dec;
        end else if (push) begin
          state_d = FULL;
          tail_d  = dec;
        end else if (pop) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (pop) begin
          state_d = ONE;
          head_d  = tail_q;
        end
      end
      default: state_d = EMPTY;
    endcase
    if (flush) begin
      state_d = EMPTY;
      head_d  = head_q;
      tail_d  = tail_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= EMPTY;
      head_q    <= '0;
      tail_q    <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      state_q   <= state_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      in_ready  <= (state_d != FULL);
      out_valid <= (state_d != EMPTY);
    end
  end

  assign out_opcode      = head_q.opcode;
  assign out_optype      = head_q.optype;
  assign out_rd          = head_q.rd;
  assign out_rs1         = head_q.rs1;
  assign out_rs2         = head_q.rs2;
  assign out_funct3      = head_q.funct3;
  assign out_funct7      = head_q.funct7;
  assign out_imm         = head_q.imm;
  assign out_pc          = head_q.pc;
  assign out_pc_next     = head_q.pc_next;
  assign out_jalr_target = head_q.jalr_target;
  assign out_compressed  = head_q.compressed;
  assign out_illegal     = head_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Randomised self-checking bench for decode_stage against a queue-based model.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_instr, in_pc, in_rs1_data;
  logic [6:0]  out_opcode, out_funct7;
  logic [2:0]  out_optype, out_funct3;
  logic [4:0]  out_rd, out_rs1, out_rs2;
  logic [31:0] out_imm, out_pc, out_pc_next, out_jalr_target;
  logic        out_compressed, out_illegal;

  always #5 clk = ~clk;

  decode_stage #(.XLEN(32), .ILEN(32), .OPT_W(3)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .in_pc(in_pc), .in_rs1_data(in_rs1_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_opcode(out_opcode), .out_optype(out_optype),
    .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2),
    .out_funct3(out_funct3), .out_funct7(out_funct7),
    .out_imm(out_imm), .out_pc(out_pc), .out_pc_next(out_pc_next),
    .out_jalr_target(out_jalr_target),
    .out_compressed(out_compressed), .out_illegal(out_illegal)
  );

  typedef struct {
    logic [6:0]  opcode;
    logic [2:0]  optype;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm, pc, pcn, jt;
    logic        comp, ill;
  } exp_t;

  exp_t q[$];
  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected decode computed from the format rules with integer arithmetic
  function automatic exp_t model(input logic [31:0] raw, input logic [31:0] pc,
                                 input logic [31:0] rs1d);
    exp_t e;
    logic [31:0] i;
    int v;
    i = raw;
    e.comp = 1'b0;
`ifdef RV_COMPRESSED_EN
    if (raw[1:0] != 2'b11) begin
      e.comp = 1'b1;
      i = (raw[15:0] == 16'h0001) ? 32'h00000013 : 32'h0;
    end
`endif
    e.opcode = i[6:0];
    e.rd = i[11:7]; e.rs1 = i[19:15]; e.rs2 = i[24:20];
    e.f3 = i[14:12]; e.f7 = i[31:25];
    e.ill = 1'b0;
    case (i[6:0])
      7'h33, 7'h53, 7'h43, 7'h47, 7'h4B, 7'h4F: e.optype = 3'd0;
      7'h13, 7'h67, 7'h03, 7'h07:               e.optype = 3'd1;
      7'h23, 7'h27:                             e.optype = 3'd2;
      7'h63:                                    e.optype = 3'd3;
      7'h37, 7'h17:                             e.optype = 3'd4;
      7'h6F:                                    e.optype = 3'd5;
      7'h73:                                    e.optype = 3'd6;
      default: begin e.optype = 3'd0; e.ill = 1'b1; end
    endcase
    case (e.optype)
      3'd1: v = int'(i[30:20]) - (i[31] ? 2048 : 0);
      3'd2: v = int'(i[30:25]) * 32 + int'(i[11:7]) - (i[31] ? 2048 : 0);
      3'd3: v = int'(i[11:8]) * 2 + int'(i[30:25]) * 32 + int'(i[7]) * 2048
                - (i[31] ? 4096 : 0);
      3'd4: v = int'(i & 32'hFFFFF000);
      3'd5: v = int'(i[30:21]) * 2 + int'(i[20]) * 2048 + int'(i[19:12]) * 4096
                - (i[31] ? 1048576 : 0);
      default: v = 0;
    endcase
    e.imm = 32'(v);
    e.pc  = pc;
    e.pcn = pc + (e.comp ? 32'd2 : 32'd4);
    e.jt  = (i[6:0] == 7'h67) ? ((rs1d + e.imm) & 32'hFFFFFFFE) : 32'h0;
    return e;
  endfunction

  task automatic check_outputs();
    chk("in_ready", 32'(in_ready), 32'(q.size() != 2));
    chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
    if (q.size() != 0) begin
      chk("opcode", 32'(out_opcode), 32'(q[0].opcode));
      chk("optype", 32'(out_optype), 32'(q[0].optype));
      chk("rd", 32'(out_rd), 32'(q[0].rd));
      chk("rs1", 32'(out_rs1), 32'(q[0].rs1));
      chk("rs2", 32'(out_rs2), 32'(q[0].rs2));
      chk("funct3", 32'(out_funct3), 32'(q[0].f3));
      chk("funct7", 32'(out_funct7), 32'(q[0].f7));
      chk("imm", out_imm, q[0].imm);
      chk("pc", out_pc, q[0].pc);
      chk("pc_next", out_pc_next, q[0].pcn);
      chk("jalr_target", out_jalr_target, q[0].jt);
      chk("compressed", 32'(out_compressed), 32'(q[0].comp));
      chk("illegal", 32'(out_illegal), 32'(q[0].ill));
    end
  endtask

  // Drive one cycle, advance the model with pre-edge state, then compare
  task automatic step(input logic v, input logic [31:0] instr, input logic [31:0] pc,
                      input logic [31:0] rs1d, input logic ordy, input logic fl);
    logic do_push, do_pop;
    in_valid = v; in_instr = instr; in_pc = pc; in_rs1_data = rs1d;
    out_ready = ordy; flush = fl;
    if (rst || fl) begin
      q.delete();
    end else begin
      do_push = v && (q.size() < 2);
      do_pop  = (q.size() > 0) && ordy;
      if (do_pop) void'(q.pop_front());
      if (do_push) q.push_back(model(instr, pc, rs1d));
    end
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  logic [6:0] ops [17] = '{7'h33, 7'h53, 7'h43, 7'h47, 7'h4B, 7'h4F, 7'h13, 7'h67,
                           7'h03, 7'h07, 7'h23, 7'h27, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h73};

  initial begin
    logic [31:0] r_instr;
    int r;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_instr = '0; in_pc = '0; in_rs1_data = '0;
    step(0, 32'h0, 32'h0, 32'h0, 0, 0);
    step(0, 32'h0, 32'h0, 32'h0, 0, 0);
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_in_ready", 32'(in_ready), 32'h1);
    chk("rst_imm", out_imm, 32'h0);
    chk("rst_pc", out_pc, 32'h0);
    chk("rst_opcode", 32'(out_opcode), 32'h0);
    rst = 1'b0;

    step(1, 32'hFFF10093, 32'h100, 32'h0, 1, 0);
    chk("addi_valid", 32'(out_valid), 32'h1);
    chk("addi_rd", 32'(out_rd), 32'd1);
    chk("addi_rs1", 32'(out_rs1), 32'd2);
    chk("addi_optype", 32'(out_optype), 32'd1);
    chk("addi_imm", out_imm, 32'hFFFFFFFF);
    chk("addi_pc_next", out_pc_next, 32'h104);
    step(1, 32'h123452B7, 32'h104, 32'h0, 1, 0);
    chk("lui_optype", 32'(out_optype), 32'd4);
    chk("lui_rd", 32'(out_rd), 32'd5);
    chk("lui_imm", out_imm, 32'h12345000);
    step(1, 32'hFFFFF06F, 32'h108, 32'h0, 1, 0);
    chk("jal_optype", 32'(out_optype), 32'd5);
    chk("jal_imm", out_imm, 32'hFFFFFFFE);
    step(1, 32'h004100E7, 32'h10C, 32'h1001, 1, 0);
    chk("jalr_target", out_jalr_target, 32'h1004);
    step(1, 32'h004100E7, 32'h110, 32'hFFFFFFFE, 1, 0);
    chk("jalr_wrap", out_jalr_target, 32'h2);
    step(1, 32'h0000007F, 32'h114, 32'h0, 1, 0);
    chk("bad_opcode_illegal", 32'(out_illegal), 32'h1);
    step(1, 32'h00000001, 32'h118, 32'h0, 1, 0);
`ifdef RV_COMPRESSED_EN
    chk("cnop_opcode", 32'(out_opcode), 32'h13);
    chk("cnop_rd", 32'(out_rd), 32'h0);
    chk("cnop_imm", out_imm, 32'h0);
    chk("cnop_compressed", 32'(out_compressed), 32'h1);
    chk("cnop_pc_next", out_pc_next, 32'h11A);
`else
    chk("cnop_illegal", 32'(out_illegal), 32'h1);
    chk("cnop_compressed", 32'(out_compressed), 32'h0);
    chk("cnop_pc_next", out_pc_next, 32'h11C);
`endif
    step(0, 32'h0, 32'h0, 32'h0, 1, 0);
    chk("drain_valid", 32'(out_valid), 32'h0);

    // Backpressure: A, B accepted, C held off until space frees
    step(1, 32'h00500093, 32'h200, 32'h0, 0, 0);
    step(1, 32'h00600113, 32'h204, 32'h0, 0, 0);
    chk("full_in_ready", 32'(in_ready), 32'h0);
    step(1, 32'h00700193, 32'h208, 32'h0, 0, 0);
    chk("hold_head_A", out_pc, 32'h200);
    step(1, 32'h00700193, 32'h208, 32'h0, 1, 0);
    chk("head_B", out_pc, 32'h204);
    chk("ready_after_pop", 32'(in_ready), 32'h1);
    step(1, 32'h00700193, 32'h208, 32'h0, 1, 0);
    chk("head_C", out_pc, 32'h208);
    step(0, 32'h0, 32'h0, 32'h0, 1, 0);
    chk("empty_after_C", 32'(out_valid), 32'h0);

    // Flush a full buffer with a push pending
    step(1, 32'h00500093, 32'h300, 32'h0, 0, 0);
    step(1, 32'h00600113, 32'h304, 32'h0, 0, 0);
    step(1, 32'h00700193, 32'h308, 32'h0, 0, 1);
    chk("flush_valid", 32'(out_valid), 32'h0);
    chk("flush_ready", 32'(in_ready), 32'h1);
    step(0, 32'h0, 32'h0, 32'h0, 1, 0);
    chk("flush_push_dropped", 32'(out_valid), 32'h0);

    for (int n = 0; n < 3000; n++) begin
      r_instr = $urandom;
      r = $urandom_range(0, 9);
      if (r < 7) r_instr[6:0] = ops[$urandom_range(0, 16)];
      else if (r < 9) r_instr[1:0] = 2'b11;
`ifdef RV_COMPRESSED_EN
      r_instr[1:0] = 2'b11;
`endif
      rst = ($urandom_range(0, 499) == 0);
      step(($urandom_range(0, 9) < 7), r_instr, $urandom, $urandom,
           ($urandom_range(0, 9) < 6), ($urandom_range(0, 29) == 0));
      rst = 1'b0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
